// File: rtl/tmem_read_responder_pkg.sv
// Shared definitions for the TMEM read responder: row/lane layout, FSM encodings
// and the tag carried alongside each SRAM read while it is in flight.
package tmem_read_responder_pkg;

   localparam int DATA_ROW_WIDTH = 96;
   localparam int LANE_WIDTH     = 32;
   localparam int NUM_LANES      = 3;

   // Lane bit positions inside a 96-bit row: X=95:64, Y=63:32, Z=31:0.
   localparam int X_MSB = 95;
   localparam int X_LSB = 64;
   localparam int Y_MSB = 63;
   localparam int Y_LSB = 32;
   localparam int Z_MSB = 31;
   localparam int Z_LSB = 0;

   typedef enum logic [1:0] {
      TMEM_RSP_IDLE  = 2'd0,
      TMEM_RSP_ISSUE = 2'd1,
      TMEM_RSP_DRAIN = 2'd2,
      TMEM_RSP_DONE  = 2'd3
   } tmem_rsp_state_e;

   typedef logic [1:0] lane_idx_t;

   localparam lane_idx_t LANE_X = 2'd0;
   localparam lane_idx_t LANE_Y = 2'd1;
   localparam lane_idx_t LANE_Z = 2'd2;

   typedef struct packed {
      logic      valid;
      lane_idx_t lane;
      logic      range_err;
   } pipe_entry_t;

   function automatic logic [LANE_WIDTH-1:0] lane_word(input logic [DATA_ROW_WIDTH-1:0] row,
                                                       input lane_idx_t idx);
      case (idx)
         LANE_X:  return row[X_MSB:X_LSB];
         LANE_Y:  return row[Y_MSB:Y_LSB];
         default: return row[Z_MSB:Z_LSB];
      endcase
   endfunction

endpackage

// File: rtl/tmem_read_responder_if.sv
// Bus bundle between the IO station (request side), the responder and the TMEM SRAM.
// Handshake: iTMEMDataRequest is a level. The responder accepts it when it is seen high while
// idle with oTMEMDataAvailable low; oTMEMDataAvailable then rises with the row and stays high
// while the request stays high, dropping the cycle after the request is seen low.
interface tmem_read_responder_if
   import tmem_read_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = 16
) ();

   logic [DATA_ROW_WIDTH-1:0] iTMEMReadAddress;
   logic                      iTMEMDataRequest;
   logic [DATA_ROW_WIDTH-1:0] oTMEMReadData;
   logic                      oTMEMDataAvailable;
   logic [ADDR_WIDTH-1:0]     oSramAddress;
   logic                      oSramReadEnable;
   logic [LANE_WIDTH-1:0]     iSramReadData;

   modport master (
      output iTMEMReadAddress,
      output iTMEMDataRequest,
      output iSramReadData,
      input  oTMEMReadData,
      input  oTMEMDataAvailable,
      input  oSramAddress,
      input  oSramReadEnable
   );

   modport slave (
      input  iTMEMReadAddress,
      input  iTMEMDataRequest,
      input  iSramReadData,
      output oTMEMReadData,
      output oTMEMDataAvailable,
      output oSramAddress,
      output oSramReadEnable
   );

endinterface

// File: rtl/tmem_read_responder_pipe.sv
// Tag shift register that tracks each issued lane for READ_LATENCY cycles, so the
// returning SRAM word can be steered to its lane (or zeroed if the lane was out of range).
module tmem_read_latency_pipe
   import tmem_read_responder_pkg::*;
#(
   parameter int READ_LATENCY = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  pipe_entry_t entry_i,
   output pipe_entry_t entry_o
);

   pipe_entry_t stage_q [READ_LATENCY];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= entry_i;
         for (int i = 1; i < READ_LATENCY; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign entry_o = stage_q[READ_LATENCY-1];

endmodule

// File: rtl/tmem_read_responder.sv
// TMEM-side responder: latches an {X,Y,Z} address request, issues three pipelined SRAM
// reads and presents the gathered 96-bit row with a registered DataAvailable.
module tmem_read_responder
   import tmem_read_responder_pkg::*;
#(
   parameter int ADDR_WIDTH   = 16,
   parameter int READ_LATENCY = 2
) (
   input  logic                  Clock,
   input  logic                  Reset,
   tmem_read_responder_if.slave  bus,
   input  logic                  iClearError,
   output logic                  oBusy,
   output logic                  oRangeError,
   output tmem_rsp_state_e       oDbgState
);

   tmem_rsp_state_e           state_q,    state_d;
   lane_idx_t                 lane_cnt_q, lane_cnt_d;
   logic [DATA_ROW_WIDTH-1:0] addr_row_q, addr_row_d;
   logic [DATA_ROW_WIDTH-1:0] gather_q,   gather_d;
   logic [DATA_ROW_WIDTH-1:0] row_q,      row_d;
   logic                      avail_q,    avail_d;
   logic [ADDR_WIDTH-1:0]     sram_addr_q, sram_addr_d;
   logic                      sram_re_q,  sram_re_d;
   pipe_entry_t               issue_q,    issue_d;
   logic                      err_q,      err_d;

   logic [LANE_WIDTH-1:0]     cur_lane_addr;
   logic [LANE_WIDTH-1:0]     landed_word;
   logic                      lane_oob;
   pipe_entry_t               pipe_out;

   // issue_q is aligned with the SRAM strobe, so the pipe delays it by exactly the SRAM latency.
   tmem_read_latency_pipe #(
      .READ_LATENCY (READ_LATENCY)
   ) u_pipe (
      .clk_i   (Clock),
      .rst_ni  (Reset),
      .entry_i (issue_q),
      .entry_o (pipe_out)
   );

   always_comb begin
      cur_lane_addr = lane_word(addr_row_q, lane_cnt_q);
      lane_oob      = (cur_lane_addr >> ADDR_WIDTH) != '0;
      landed_word   = pipe_out.range_err ? '0 : bus.iSramReadData;

      state_d     = state_q;
      lane_cnt_d  = lane_cnt_q;
      addr_row_d  = addr_row_q;
      gather_d    = gather_q;
      row_d       = row_q;
      avail_d     = avail_q;
      sram_addr_d = sram_addr_q;
      sram_re_d   = 1'b0;
      issue_d     = '0;
      err_d       = err_q;

      if (iClearError) begin
         err_d = 1'b0;
      end

      // Returns can land while still issuing when READ_LATENCY is short, so this is state-independent.
      if (pipe_out.valid) begin
         case (pipe_out.lane)
            LANE_X:  gather_d[X_MSB:X_LSB] = landed_word;
            LANE_Y:  gather_d[Y_MSB:Y_LSB] = landed_word;
            default: gather_d[Z_MSB:Z_LSB] = landed_word;
         endcase
      end

      case (state_q)
         TMEM_RSP_IDLE: begin
            if (bus.iTMEMDataRequest && !avail_q) begin
               addr_row_d = bus.iTMEMReadAddress;
               lane_cnt_d = LANE_X;
               state_d    = TMEM_RSP_ISSUE;
            end
         end
         TMEM_RSP_ISSUE: begin
            sram_addr_d = cur_lane_addr[ADDR_WIDTH-1:0];
            sram_re_d   = !lane_oob;
            issue_d     = '{valid: 1'b1, lane: lane_cnt_q, range_err: lane_oob};
            if (lane_oob) begin
               err_d = 1'b1;
            end
            if (lane_cnt_q == LANE_Z) begin
               state_d = TMEM_RSP_DRAIN;
            end else begin
               lane_cnt_d = lane_cnt_q + 2'd1;
            end
         end
         TMEM_RSP_DRAIN: begin
            if (pipe_out.valid && (pipe_out.lane == LANE_Z)) begin
               row_d   = {gather_q[X_MSB:Y_LSB], landed_word};
               avail_d = 1'b1;
               state_d = TMEM_RSP_DONE;
            end
         end
         TMEM_RSP_DONE: begin
            if (!bus.iTMEMDataRequest) begin
               avail_d = 1'b0;
               state_d = TMEM_RSP_IDLE;
            end
         end
         default: begin
            state_d = TMEM_RSP_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q     <= TMEM_RSP_IDLE;
         lane_cnt_q  <= LANE_X;
         addr_row_q  <= '0;
         gather_q    <= '0;
         row_q       <= '0;
         avail_q     <= 1'b0;
         sram_addr_q <= '0;
         sram_re_q   <= 1'b0;
         issue_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         lane_cnt_q  <= lane_cnt_d;
         addr_row_q  <= addr_row_d;
         gather_q    <= gather_d;
         row_q       <= row_d;
         avail_q     <= avail_d;
         sram_addr_q <= sram_addr_d;
         sram_re_q   <= sram_re_d;
         issue_q     <= issue_d;
         err_q       <= err_d;
      end
   end

   assign bus.oTMEMReadData      = row_q;
   assign bus.oTMEMDataAvailable = avail_q;
   assign bus.oSramAddress       = sram_addr_q;
   assign bus.oSramReadEnable    = sram_re_q;
   assign oBusy                  = (state_q == TMEM_RSP_ISSUE) || (state_q == TMEM_RSP_DRAIN);
   assign oRangeError            = err_q;
   assign oDbgState              = state_q;

endmodule

// File: tb/tb_tmem_read_responder.sv
// Bench for tmem_read_responder: four instances (READ_LATENCY 1..4) share one request stream;
// a transaction-timeline model predicts every output each cycle, plus directed literal checks.
module tb_tmem_read_responder;
   import tmem_read_responder_pkg::*;

   localparam int NI = 4;
   localparam int AW = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic        clr_err = 1'b0;
   logic [95:0] req_addr = '0;
   logic        chk_en = 1'b0;

   always #5 clk = ~clk;

   logic [31:0] mem [0:1023];
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hE000_0000 | i;
      mem[5] = 32'hA1A1_A1A1;
      mem[6] = 32'hB2B2_B2B2;
      mem[7] = 32'hC3C3_C3C3;
   end

   logic [NI-1:0]   avail, busy, re, rerr;
   logic [95:0]     rdata [NI];
   logic [AW-1:0]   saddr [NI];
   tmem_rsp_state_e dbg   [NI];
   int              sc    [NI];

   int errors = 0;
   int checks = 0;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int L = g + 1;
      tmem_read_responder_if #(.ADDR_WIDTH(AW)) bus ();
      logic [31:0] rd_pipe [L];

      assign bus.iTMEMReadAddress = req_addr;
      assign bus.iTMEMDataRequest = req;

      always @(posedge clk) begin
         rd_pipe[0] <= bus.oSramReadEnable ? mem[bus.oSramAddress[9:0]] : 32'hDEAD_BEEF;
         for (int k = 1; k < L; k++) rd_pipe[k] <= rd_pipe[k-1];
      end
      assign bus.iSramReadData = rd_pipe[L-1];

      tmem_read_responder #(
         .ADDR_WIDTH   (AW),
         .READ_LATENCY (L)
      ) u_dut (
         .Clock       (clk),
         .Reset       (rst_n),
         .bus         (bus),
         .iClearError (clr_err),
         .oBusy       (busy[g]),
         .oRangeError (rerr[g]),
         .oDbgState   (dbg[g])
      );

      assign avail[g] = bus.oTMEMDataAvailable;
      assign re[g]    = bus.oSramReadEnable;
      assign rdata[g] = bus.oTMEMReadData;
      assign saddr[g] = bus.oSramAddress;
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] lane_of(input logic [95:0] row, input int i);
      return row[95-32*i -: 32];
   endfunction

   function automatic logic lane_oob(input logic [31:0] a);
      return a[31:16] != 16'h0;
   endfunction

   function automatic logic [95:0] expected_row(input logic [95:0] addr);
      logic [95:0] r;
      logic [31:0] a;
      r = '0;
      for (int i = 0; i < 3; i++) begin
         a = lane_of(addr, i);
         r[95-32*i -: 32] = lane_oob(a) ? 32'h0 : mem[a[9:0]];
      end
      return r;
   endfunction

   // ---------------- model: cycles since acceptance per instance ----------------
   int          m_t    [NI];
   logic        m_done [NI];
   logic [95:0] m_addr [NI];
   logic [95:0] m_row  [NI];
   logic        m_err  [NI];

   always @(posedge clk) begin
      for (int g = 0; g < NI; g++) begin
         if (!rst_n) begin
            m_t[g] = -1; m_done[g] = 1'b0; m_row[g] = '0; m_err[g] = 1'b0; m_addr[g] = '0;
         end else begin
            if (clr_err) m_err[g] = 1'b0;
            if (m_done[g]) begin
               if (!req) m_done[g] = 1'b0;
            end else if (m_t[g] >= 0) begin
               m_t[g]++;
               if (m_t[g] <= 3 && lane_oob(lane_of(m_addr[g], m_t[g] - 1))) m_err[g] = 1'b1;
               if (m_t[g] == 4 + g + 1) begin
                  m_row[g]  = expected_row(m_addr[g]);
                  m_done[g] = 1'b1;
                  m_t[g]    = -1;
               end
            end else if (req) begin
               m_t[g]    = 0;
               m_addr[g] = req_addr;
            end
         end
      end
   end

   always @(posedge clk) begin
      for (int g = 0; g < NI; g++) if (re[g]) sc[g]++;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int g = 0; g < NI; g++) begin
            logic exp_re;
            exp_re = (m_t[g] >= 1) && (m_t[g] <= 3) && !lane_oob(lane_of(m_addr[g], m_t[g] - 1));
            chk($sformatf("L%0d avail", g+1), 96'(avail[g]), 96'(m_done[g]));
            chk($sformatf("L%0d busy", g+1), 96'(busy[g]), 96'(m_t[g] >= 0));
            chk($sformatf("L%0d strobe", g+1), 96'(re[g]), 96'(exp_re));
            if (exp_re)
               chk($sformatf("L%0d sram_addr", g+1), 96'(saddr[g]),
                   96'(lane_of(m_addr[g], m_t[g] - 1) & 32'h0000_FFFF));
            chk($sformatf("L%0d range_err", g+1), 96'(rerr[g]), 96'(m_err[g]));
            chk($sformatf("L%0d row", g+1), rdata[g], m_row[g]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic settle();
      int k;
      k = 0;
      req = 1'b0;
      while (((busy | avail) != '0) && k < 40) begin
         tick(1);
         k++;
      end
      chk("settle idle", 96'({busy, avail}), 96'(0));
   endtask

   task automatic wait_all_avail();
      int k;
      k = 0;
      while (avail != 4'hF && k < 20) begin
         tick(1);
         k++;
      end
      chk("all avail", 96'(avail), 96'(4'hF));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int k, snap, cnt;
      logic [31:0] a;
      rst_n = 1'b0;
      tick(1);
      chk_en = 1'b1;
      tick(2);
      for (int g = 0; g < NI; g++) begin
         chk("reset avail", 96'(avail[g]), 96'(0));
         chk("reset busy", 96'(busy[g]), 96'(0));
         chk("reset strobe", 96'(re[g]), 96'(0));
         chk("reset row", rdata[g], 96'(0));
         chk("reset state", 96'(dbg[g]), 96'(TMEM_RSP_IDLE));
      end
      rst_n = 1'b1;
      tick(1);

      // Basic row {5,6,7}, latency 2 instance timed exactly.
      snap = sc[1];
      req_addr = {32'd5, 32'd6, 32'd7};
      req = 1'b1;
      tick(1);
      k = 0;
      while (!avail[1] && k < 20) begin
         tick(1);
         k++;
      end
      chk("t2 avail cycle", 96'(k), 96'(6));
      chk("t2 row", rdata[1], 96'hA1A1A1A1_B2B2B2B2_C3C3C3C3);
      chk("t2 strobes", 96'(sc[1] - snap), 96'(3));
      req = 1'b0;
      tick(1);
      chk("t2 drop", 96'(avail[1]), 96'(0));
      settle();

      // Request held: Available holds, no new reads.
      req_addr = {32'd10, 32'd20, 32'd30};
      req = 1'b1;
      wait_all_avail();
      snap = sc[1];
      tick(10);
      chk("t3 hold avail", 96'(avail), 96'(4'hF));
      chk("t3 no strobes", 96'(sc[1] - snap), 96'(0));
      req = 1'b0;
      tick(1);
      chk("t3 release", 96'(avail), 96'(0));
      settle();

      // Y lane out of range.
      snap = sc[1];
      req_addr = {32'h10, 32'h0001_0000, 32'h20};
      req = 1'b1;
      wait_all_avail();
      chk("t4 row", rdata[1], 96'hE0000010_00000000_E0000020);
      chk("t4 strobes", 96'(sc[1] - snap), 96'(2));
      settle();
      chk("t4 sticky", 96'(rerr), 96'(4'hF));
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
      chk("t4 cleared", 96'(rerr), 96'(0));

      // Request dropped at cycle 2: row completes, one-cycle pulse.
      req_addr = {32'd100, 32'd200, 32'd300};
      req = 1'b1;
      tick(3);
      req = 1'b0;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         if (avail[1]) cnt++;
      end
      chk("t5 pulse", 96'(cnt), 96'(1));
      chk("t5 row", rdata[1], 96'hE0000064_E00000C8_E000012C);
      settle();

      // Reset mid-DRAIN, then a fresh row.
      req_addr = {32'd40, 32'd41, 32'd42};
      req = 1'b1;
      tick(5);
      rst_n = 1'b0;
      req = 1'b0;
      tick(3);
      chk("t1 avail", 96'(avail), 96'(0));
      chk("t1 busy", 96'(busy), 96'(0));
      chk("t1 strobe", 96'(re), 96'(0));
      rst_n = 1'b1;
      tick(1);
      req_addr = {32'd7, 32'd5, 32'd6};
      req = 1'b1;
      wait_all_avail();
      chk("t1 fresh row", rdata[1], 96'hC3C3C3C3_A1A1A1A1_B2B2B2B2);
      settle();

      // Sweep with random addresses across all four latencies.
      for (int n = 0; n < 12; n++) begin
         for (int i = 0; i < 3; i++) begin
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 4) == 0) a = a | (32'h0001_0000 << $urandom_range(0, 15));
            req_addr[95-32*i -: 32] = a;
         end
         req = 1'b1;
         if (n % 3 == 0) begin
            tick(2);
            req = 1'b0;
         end else begin
            wait_all_avail();
            tick($urandom_range(0, 3));
         end
         settle();
         clr_err = 1'b1;
         tick(1);
         clr_err = 1'b0;
      end

      tick(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
